// File: rtl/hamming_word_arbiter.sv
// ---------------------------------------------------------------------------
// hamming_word_arbiter
//
// Round-robin arbiter sharing one 16-bit Avalon-ST word path among NUM_IN
// sources. A grant lasts at most BURST_LEN accepted words, or ends early as
// soon as the granted source drops valid. Accepted words go through a single
// registered output stage and are tagged with the index of their source.
//
// Handshake: a word moves on a rising clock edge when valid and ready are
// both high on that interface. Ready never depends on valid. A source that
// raises valid holds its data until it is accepted.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     per-source valid, bit i = source i
//   in_ready     per-source ready, at most one bit high (the granted source)
//   in_data      per-source words, source i at [16i+15:16i]
//   out_ready    downstream ready
//   out_valid    output register holds a word
//   out_data     registered word
//   out_channel  source index of out_data
//   busy         high while a grant is held (FSM state GRANTED)
// ---------------------------------------------------------------------------
module hamming_word_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int BURST_LEN = 4,
  parameter int CH_W      = $clog2(NUM_IN)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_IN-1:0]    in_valid,
  output logic [NUM_IN-1:0]    in_ready,
  input  logic [16*NUM_IN-1:0] in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic [CH_W-1:0]      out_channel,
  output logic                 busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CH_W-1:0] g, g_n;
  logic [CH_W-1:0] rr_ptr, rr_ptr_n;
  logic [CH_W-1:0] sel;
  logic [7:0]      burst_cnt, burst_cnt_n;
  logic            found;
  logic            g_valid;
  logic            g_ready;
  logic            xfer;
  logic [15:0]     words [NUM_IN];

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      words[i] = in_data[16*i +: 16];
    end
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_IN). The loop runs from the far end
  // back towards rr_ptr so the last hit written is the nearest one.
  always_comb begin
    int pos;
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      pos = (int'(rr_ptr) + i) % NUM_IN;
      if (in_valid[pos[CH_W-1:0]]) begin
        sel   = pos[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

  // The output register can take a word when it is empty or draining now.
  assign g_valid = in_valid[g];
  assign g_ready = ~out_valid | out_ready;
  assign xfer    = (state == GRANTED) & g_valid & g_ready;
  assign busy    = (state == GRANTED);

  always_comb begin
    in_ready = '0;
    if (state == GRANTED) begin
      in_ready[g] = g_ready;
    end
  end

  always_comb begin
    state_n     = state;
    g_n         = g;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          g_n         = sel;
          burst_cnt_n = 8'(BURST_LEN);
          state_n     = GRANTED;
        end
      end
      GRANTED: begin
        // Early release on a dropped valid; a stall (valid, not ready)
        // leaves both the grant and the burst count untouched.
        if (!g_valid || (xfer && burst_cnt == 8'd1)) begin
          state_n  = IDLE;
          rr_ptr_n = (g == CH_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
        end
        if (xfer) begin
          burst_cnt_n = burst_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      g         <= g_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= 16'h0000;
      out_channel <= '0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_data    <= words[g];
      out_channel <= g;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_word_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for hamming_word_arbiter. Two instances share the stimulus: dut_a
// with BURST_LEN=4 and dut_b with BURST_LEN=2; use_b picks which one the
// sources and the reference model follow. The reference model describes
// the arbiter as grants (owner, words left, next pointer) and an output
// slot, advanced once per clock. Sources are word arrays with head/tail.
// ---------------------------------------------------------------------------
module tb_hamming_word_arbiter;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // stimulus
  logic [3:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b1;

  // dut outputs
  logic [3:0]  rdy_a, rdy_b, rdy;
  logic        ov_a, ov_b, ov;
  logic [15:0] od_a, od_b, od;
  logic [1:0]  oc_a, oc_b, oc;
  logic        busy_a, busy_b, bsy;
  bit          use_b = 1'b0;

  assign rdy = use_b ? rdy_b : rdy_a;
  assign ov  = use_b ? ov_b  : ov_a;
  assign od  = use_b ? od_b  : od_a;
  assign oc  = use_b ? oc_b  : oc_a;
  assign bsy = use_b ? busy_b : busy_a;

  hamming_word_arbiter #(.NUM_IN(4), .BURST_LEN(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .out_ready(out_ready), .out_valid(ov_a),
    .out_data(od_a), .out_channel(oc_a), .busy(busy_a)
  );

  hamming_word_arbiter #(.NUM_IN(4), .BURST_LEN(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .out_ready(out_ready), .out_valid(ov_b),
    .out_data(od_b), .out_channel(oc_b), .busy(busy_b)
  );

  // sources
  logic [15:0] src_mem [4][32];
  int          src_head [4];
  int          src_tail [4];
  logic [3:0]  src_en = 4'hF;

  // reference model
  bit          m_busy;
  int          m_g, m_rr, m_left, m_bl;
  bit          m_ov;
  logic [15:0] m_od;
  logic [1:0]  m_oc;

  // adapter model (16-to-8, high byte first)
  bit          ad_mode;
  int          ad_cnt;
  logic [15:0] ad_word;
  logic [7:0]  byte_log [$];

  // scoreboard: trace = {in_ready, busy, out_valid, out_data, out_channel}
  logic [23:0] tr_dut [$];
  logic [23:0] tr_mdl [$];
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];
  int          got_t [$];
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;

  // driver tasks
  task automatic clear_logs();
    tr_dut.delete(); tr_mdl.delete(); exp_q.delete(); got_q.delete();
    got_t.delete(); byte_log.delete(); cyc = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_rr = 0; m_left = 0; m_ov = 0; m_od = '0; m_oc = '0;
    m_bl = use_b ? 2 : 4;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    src_en = 4'hF; ad_mode = 0; ad_cnt = 0; ad_word = '0;
    for (int s = 0; s < 4; s++) begin
      src_head[s] = 0; src_tail[s] = 0;
      for (int j = 0; j < 32; j++) src_mem[s][j] = '0;
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic load_src(input int s, input int n, input logic [15:0] base);
    for (int j = 0; j < n; j++) src_mem[s][src_tail[s] + j] = base + 16'(j);
    src_tail[s] += n;
  endtask

  // One clock: drive sources, sample DUT and model before the edge, advance
  // the model by the rules of the block, then step past the edge.
  task automatic cycle();
    logic [3:0] iv, er;
    int acc;
    bit drain;
    iv = '0;
    for (int i = 0; i < 4; i++) begin
      if (src_en[i] && src_head[i] < src_tail[i]) iv[i] = 1'b1;
      in_data[16*i +: 16] = (src_head[i] < 32) ? src_mem[i][src_head[i]] : 16'h0;
    end
    in_valid = iv;
    #1;
    er = '0;
    if (m_busy) er[m_g] = !m_ov || out_ready;
    tr_dut.push_back({rdy, bsy, ov, ov ? od : 16'h0, ov ? oc : 2'b0});
    tr_mdl.push_back({er, m_busy, m_ov, m_ov ? m_od : 16'h0, m_ov ? m_oc : 2'b0});
    if (ov && out_ready) begin
      got_q.push_back({oc, od});
      got_t.push_back(cyc);
    end
    drain = m_ov && out_ready;
    if (drain) exp_q.push_back({m_oc, m_od});
    if (ad_cnt != 0) begin
      byte_log.push_back(ad_cnt == 2 ? ad_word[15:8] : ad_word[7:0]);
      ad_cnt--;
    end
    if (ad_mode && ov && out_ready) begin
      ad_word = od; ad_cnt = 2;
    end
    acc = -1;
    if (m_busy && iv[m_g] && er[m_g]) acc = m_g;
    if (acc >= 0) begin
      m_od = src_mem[acc][src_head[acc]]; m_oc = 2'(acc); m_ov = 1;
      src_head[acc]++;
    end else if (drain) begin
      m_ov = 0;
    end
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && iv[(m_rr + k) % 4]) begin
          m_busy = 1; m_g = (m_rr + k) % 4; m_left = m_bl;
        end
      end
    end else if (!iv[m_g] || (acc >= 0 && m_left == 1)) begin
      m_busy = 0; m_rr = (m_g + 1) % 4;
    end else if (acc >= 0) begin
      m_left--;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // tests
  task automatic test_reset();
    use_b = 0; do_reset();
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", ov_a); end
    n_checks++; if (od_a !== 16'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0000", od_a); end
    n_checks++; if (oc_a !== 2'd0) begin n_fail++; $display("FAIL reset out_channel: got %0d want 0", oc_a); end
    n_checks++; if (rdy_a !== 4'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0000", rdy_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy_a); end
    n_checks++; if ({busy_b, ov_b, rdy_b} !== 6'b0) begin n_fail++; $display("FAIL reset dut_b: got %b want 0", {busy_b, ov_b, rdy_b}); end
  endtask

  task automatic test_single_source();
    int first_busy, zeros;
    use_b = 0; do_reset();
    load_src(2, 6, 16'hA001);
    repeat (14) cycle();
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin n_fail++; $display("FAIL single trace c%0d: got %h want %h", k, tr_dut[k], tr_mdl[k]); end
    end
    n_checks++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL single count: got %0d want 6", got_q.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got_q[k] !== {2'd2, 16'hA001 + 16'(k)}) begin n_fail++; $display("FAIL single word %0d: got %h want %h", k, got_q[k], {2'd2, 16'hA001 + 16'(k)}); end
      end
      for (int k = 1; k < 6; k++) begin
        n_checks++;
        if (got_t[k] - got_t[k-1] != (k == 4 ? 2 : 1)) begin n_fail++; $display("FAIL single spacing %0d: got %0d want %0d", k, got_t[k] - got_t[k-1], (k == 4 ? 2 : 1)); end
      end
      first_busy = -1; zeros = 0;
      for (int k = 0; k < got_t[5]; k++) begin
        if (first_busy < 0 && tr_dut[k][19]) first_busy = k;
        else if (first_busy >= 0 && !tr_dut[k][19]) zeros++;
      end
      n_checks++;
      if (zeros != 1) begin n_fail++; $display("FAIL single busy gap: got %0d cycles want 1", zeros); end
    end
  endtask

  task automatic test_round_robin();
    int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int used [4] = '{0, 0, 0, 0};
    logic [17:0] want;
    use_b = 1; do_reset();
    for (int s = 0; s < 4; s++) load_src(s, 4, 16'h1000 * 16'(s + 1));
    repeat (18) cycle();
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin n_fail++; $display("FAIL rr trace c%0d: got %h want %h", k, tr_dut[k], tr_mdl[k]); end
    end
    n_checks++;
    if (got_q.size() < 10) begin n_fail++; $display("FAIL rr count: got %0d want >=10", got_q.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        want = {2'(seq[k]), 16'h1000 * 16'(seq[k] + 1) + 16'(used[seq[k]])};
        used[seq[k]]++;
        n_checks++;
        if (got_q[k] !== want) begin n_fail++; $display("FAIL rr word %0d: got %h want %h", k, got_q[k], want); end
      end
    end
    use_b = 0;
  endtask

  task automatic test_early_release();
    int seq [8] = '{1, 1, 2, 2, 2, 2, 1, 1};
    bit dropped;
    use_b = 0; do_reset();
    load_src(1, 4, 16'h1100);
    load_src(2, 4, 16'h2200);
    dropped = 0;
    for (int c = 0; c < 20; c++) begin
      if (src_head[1] == 2 && !dropped) begin src_en[1] = 1'b0; dropped = 1; end
      else src_en[1] = 1'b1;
      cycle();
    end
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin n_fail++; $display("FAIL early trace c%0d: got %h want %h", k, tr_dut[k], tr_mdl[k]); end
    end
    n_checks++;
    if (got_q.size() != 8) begin n_fail++; $display("FAIL early count: got %0d want 8", got_q.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (got_q[k][17:16] !== 2'(seq[k])) begin n_fail++; $display("FAIL early channel %0d: got %0d want %0d", k, got_q[k][17:16], seq[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat [16] = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    bit pre_ov;
    logic [15:0] pre_od;
    use_b = 0; do_reset();
    load_src(0, 6, 16'hB000);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c < 16) ? pat[c] : 1'b1;
      pre_ov = ov_a; pre_od = od_a;
      cycle();
      if (pre_ov && !out_ready) begin
        n_checks++;
        if (ov_a !== 1'b1 || od_a !== pre_od) begin n_fail++; $display("FAIL bp hold c%0d: got %b/%h want 1/%h", c, ov_a, od_a, pre_od); end
      end
    end
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin n_fail++; $display("FAIL bp trace c%0d: got %h want %h", k, tr_dut[k], tr_mdl[k]); end
    end
    n_checks++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL bp count: got %0d want 6", got_q.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got_q[k] !== {2'd0, 16'hB000 + 16'(k)}) begin n_fail++; $display("FAIL bp word %0d: got %h want %h", k, got_q[k], {2'd0, 16'hB000 + 16'(k)}); end
      end
    end
  endtask

  task automatic test_adapter();
    logic [7:0] want [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    bit empty;
    use_b = 0; do_reset();
    ad_mode = 1;
    src_mem[0][0] = 16'h1234; src_mem[0][1] = 16'h5678; src_tail[0] = 2;
    for (int c = 0; c < 12; c++) begin
      empty = (ad_cnt == 0);
      out_ready = empty;
      cycle();
      n_checks++;
      if (tr_dut[c][20] && tr_dut[c][18] && !empty) begin n_fail++; $display("FAIL adapter ready c%0d: got 1 want 0", c); end
    end
    n_checks++;
    if (byte_log.size() != 4) begin n_fail++; $display("FAIL adapter bytes: got %0d want 4", byte_log.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (byte_log[k] !== want[k]) begin n_fail++; $display("FAIL adapter byte %0d: got %h want %h", k, byte_log[k], want[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    use_b = 0; do_reset();
    load_src(0, 4, 16'hC000);
    load_src(1, 8, 16'hD000);
    repeat (8) cycle();
    n_checks++;
    if (ov_a !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL midrst pre: got %b%b want 11", ov_a, busy_a); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ov_a, busy_a, rdy_a} !== 6'b0) begin n_fail++; $display("FAIL midrst async: got %b want 000000", {ov_a, busy_a, rdy_a}); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset(); clear_logs();
    load_src(0, 4, 16'hC004);
    repeat (8) cycle();
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin n_fail++; $display("FAIL midrst trace c%0d: got %h want %h", k, tr_dut[k], tr_mdl[k]); end
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== {2'd0, 16'hC004}) begin n_fail++; $display("FAIL midrst first word: got %h want %h", (got_q.size() != 0) ? got_q[0] : 18'h0, {2'd0, 16'hC004}); end
  endtask

  task automatic test_random(input bit b);
    int bad;
    use_b = b; do_reset();
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 20; j++) src_mem[s][j] = 16'($urandom);
      src_tail[s] = 20;
    end
    repeat (300) begin
      src_en = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    src_en = 4'hF; out_ready = 1'b1;
    repeat (120) cycle();
    bad = 0;
    for (int k = 0; k < tr_dut.size(); k++) begin
      n_checks++;
      if (tr_dut[k] !== tr_mdl[k]) begin
        n_fail++;
        if (bad++ < 5) $display("FAIL random%0d trace c%0d: got %h want %h", b, k, tr_dut[k], tr_mdl[k]);
      end
    end
    n_checks++;
    if (got_q.size() != 80 || exp_q.size() != 80) begin n_fail++; $display("FAIL random%0d count: got %0d want 80", b, got_q.size()); end
    else begin
      for (int k = 0; k < 80; k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL random%0d word %0d: got %h want %h", b, k, got_q[k], exp_q[k]); end
      end
    end
    use_b = 0;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_adapter();
    test_reset_mid_burst();
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
